// File: rtl/timer_pkg.sv
// Shared types and helpers for the transaction-layer timer bank.
package timer_pkg;

  // Per-channel lifecycle.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StExpired = 2'd2
  } ch_state_e;

  // Channel-ID width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping to the bottom.
module rr_arbiter import timer_pkg::*; #(
  parameter int unsigned NUM_CH = 8,
  localparam int unsigned ID_W  = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              found
);

  // Two passes: upper segment from ptr first, then the wrapped lower segment.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH timeout channels sharing one prescaled tick; expired channels
// are reported one at a time on a valid/ready port with round-robin fairness.
module timer_bank import timer_pkg::*; #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 4,
  localparam int unsigned ID_W    = id_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  input  logic [ID_W-1:0]   start_id,
  input  logic              stop_valid,
  input  logic [ID_W-1:0]   stop_id,
  input  logic [WIDTH-1:0]  timeout_cfg,
  output logic              expired_valid,
  output logic [ID_W-1:0]   expired_id,
  input  logic              expired_ready,
  output logic [NUM_CH-1:0] active,
  output logic              tick
);

  localparam int unsigned    PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc_q, presc_d;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [WIDTH-1:0] count_q [NUM_CH];
  logic [WIDTH-1:0] count_d [NUM_CH];

  logic [NUM_CH-1:0] start_hit, stop_hit, take, arb_req, arb_grant;
  logic [NUM_CH-1:0] presented_oh_q;
  logic [ID_W-1:0]   ptr_q, ptr_next, arb_id;
  logic              arb_found, handshake, withdraw;

  // Prescaler wraps at PRESCALE-1.
  always_comb begin
    presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
  end

  // Tick is registered so it is high exactly while the prescaler sits at PRESCALE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick    <= (presc_d == PS_LAST);
    end
  end

  // Decode per-channel commands; out-of-range IDs match no channel.
  always_comb begin
    handshake = expired_valid && expired_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      start_hit[i] = start_valid && (start_id == ID_W'(i));
      stop_hit[i]  = stop_valid && (stop_id == ID_W'(i));
      take[i]      = handshake && presented_oh_q[i];
      // A channel being restarted or stopped this cycle must not be picked.
      arb_req[i]   = (state_q[i] == StExpired) && !start_hit[i] && !stop_hit[i];
    end
    withdraw = expired_valid && |(presented_oh_q & (start_hit | stop_hit));
  end

  // Channel next state: start > stop > handshake retire > tick update.
  always_comb begin
    logic [WIDTH-1:0] inc;
    inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      inc        = (count_q[i] == '1) ? count_q[i] : count_q[i] + WIDTH'(1);
      if (start_hit[i]) begin
        state_d[i] = StRunning;
        count_d[i] = '0;
      end else if (stop_hit[i]) begin
        if (state_q[i] != StIdle) begin
          state_d[i] = StIdle;
          count_d[i] = '0;
        end
      end else if (take[i]) begin
        state_d[i] = StIdle;
        count_d[i] = '0;
      end else if ((state_q[i] == StRunning) && tick) begin
        count_d[i] = inc;
        if ((timeout_cfg != '0) && (inc >= timeout_cfg)) begin
          state_d[i] = StExpired;
        end
      end
    end
  end

  // Channel state, counts and the registered RUNNING flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        count_q[i] <= '0;
      end
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        active[i]  <= (state_d[i] == StRunning);
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req      (arb_req),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .found    (arb_found)
  );

  always_comb begin
    ptr_next = (expired_id == ID_W'(NUM_CH - 1)) ? '0 : expired_id + ID_W'(1);
  end

  // Expiry port: present, hold until accepted or withdrawn, then idle one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      expired_valid  <= 1'b0;
      expired_id     <= '0;
      presented_oh_q <= '0;
      ptr_q          <= '0;
    end else if (expired_valid) begin
      if (handshake) begin
        expired_valid  <= 1'b0;
        presented_oh_q <= '0;
        ptr_q          <= ptr_next;
      end else if (withdraw) begin
        expired_valid  <= 1'b0;
        presented_oh_q <= '0;
      end
    end else if (arb_found) begin
      expired_valid  <= 1'b1;
      expired_id     <= arb_id;
      presented_oh_q <= arb_grant;
    end
  end

endmodule
